// File: rtl/fg_pkg.sv
// Shared definitions for the function generator host link.
package fg_pkg;

  localparam int CMD_RD_BIT = 7;
  localparam int ADDR_W     = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } spi_st_t;

endpackage

// File: rtl/sync_edge.sv
// N-flop synchroniser for an asynchronous pin, with registered rise/fall pulses.
// lvl_o is the delayed level, aligned with the pulses so that a consumer sees
// the new level in the same cycle as the edge pulse.
module sync_edge #(
  parameter int STAGES = 2,
  parameter bit INIT   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic              r_rise;
  logic              r_fall;

  // Shift the pin through the chain and flag transitions of the settled level.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sync <= {STAGES{INIT}};
      r_prev <= INIT;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d_i};
      r_prev <= r_sync[STAGES-1];
      r_rise <= r_sync[STAGES-1] & ~r_prev;
      r_fall <= ~r_sync[STAGES-1] & r_prev;
    end
  end

  assign lvl_o  = r_prev;
  assign rise_o = r_rise;
  assign fall_o = r_fall;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI slave decoding one command byte plus DATA_BYTES payload bytes into
// single-cycle register write/read strobes in the system clock domain.
module spi_reg_slave
  import fg_pkg::*;
#(
  parameter int  DATA_BYTES  = 3,
  parameter bit  CPOL        = 1'b0,
  parameter bit  CPHA        = 1'b0,
  parameter int  SYNC_STAGES = 2,
  localparam int DATA_W      = 8 * DATA_BYTES
) (
  input  logic              sys_clk_i,
  input  logic              sys_rst_i,
  input  logic              spi_clk_i,
  input  logic              spi_mosi_i,
  input  logic              spi_cs_i,
  output logic              spi_miso_o,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic [DATA_W-1:0] reg_wdata_o,
  output logic              reg_we_o,
  output logic              reg_re_o,
  input  logic [DATA_W-1:0] reg_rdata_i,
  output logic              frame_err_o
);

  localparam int CNT_W          = $clog2(DATA_W + 8);
  localparam bit SAMPLE_ON_RISE = ((CPOL ^ CPHA) == 1'b0);
  // Edges seen before the synchronisers have flushed their reset value are
  // not trusted; after that a high CS level is required before a frame may
  // start, so a frame interrupted by reset is skipped until CS toggles.
  localparam int SETTLE         = SYNC_STAGES + 1;
  localparam int SET_W          = $clog2(SETTLE + 1);

  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_mosi_lvl, w_mosi_rise, w_mosi_fall;
  logic w_cs_lvl, w_cs_rise, w_cs_fall;

  sync_edge #(.STAGES(SYNC_STAGES), .INIT(CPOL)) u_sync_sclk (
    .clk_i(sys_clk_i), .rst_n_i(sys_rst_i), .d_i(spi_clk_i),
    .lvl_o(w_sclk_lvl), .rise_o(w_sclk_rise), .fall_o(w_sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_mosi (
    .clk_i(sys_clk_i), .rst_n_i(sys_rst_i), .d_i(spi_mosi_i),
    .lvl_o(w_mosi_lvl), .rise_o(w_mosi_rise), .fall_o(w_mosi_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_sync_cs (
    .clk_i(sys_clk_i), .rst_n_i(sys_rst_i), .d_i(spi_cs_i),
    .lvl_o(w_cs_lvl), .rise_o(w_cs_rise), .fall_o(w_cs_fall)
  );

  logic w_unused_ok;
  assign w_unused_ok = ^{w_sclk_lvl, w_mosi_rise, w_mosi_fall};

  logic w_sample, w_shift;
  assign w_sample = SAMPLE_ON_RISE ? w_sclk_rise : w_sclk_fall;
  assign w_shift  = SAMPLE_ON_RISE ? w_sclk_fall : w_sclk_rise;

  spi_st_t           r_state, w_state_next;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0] r_rx, r_tx;
  logic [DATA_W-1:0] w_rx_next;
  logic              r_is_rd, r_cap, r_miso;
  logic              r_we, r_re, r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [SET_W-1:0]  r_settle_cnt;
  logic              r_armed;

  logic w_frame_start, w_abort, w_rx_shift, w_cmd_done, w_data_done, w_tx_shift;

  assign w_rx_next = {r_rx[DATA_W-2:0], w_mosi_lvl};

  // Arm frame decoding once the synchronisers are flushed and CS is seen high.
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      r_settle_cnt <= '0;
      r_armed      <= 1'b0;
    end else if (r_settle_cnt != SET_W'(SETTLE)) begin
      r_settle_cnt <= r_settle_cnt + SET_W'(1);
    end else if (w_cs_lvl) begin
      r_armed <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) r_state <= IDLE;
    else            r_state <= w_state_next;
  end

  // FSM next state; a CS rise always beats a coincident sample edge.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: if (w_cs_fall && r_armed) w_state_next = CMD;
      CMD: begin
        if (w_cs_rise)                                         w_state_next = IDLE;
        else if (w_sample && r_bit_cnt == CNT_W'(7))           w_state_next = DATA;
      end
      DATA: begin
        if (w_cs_rise)                                         w_state_next = IDLE;
        else if (w_sample && r_bit_cnt == CNT_W'(DATA_W - 1))  w_state_next = DONE;
      end
      DONE: if (w_cs_rise) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // FSM outputs: per-cycle datapath controls.
  always_comb begin
    w_frame_start = 1'b0;
    w_abort       = 1'b0;
    w_rx_shift    = 1'b0;
    w_cmd_done    = 1'b0;
    w_data_done   = 1'b0;
    w_tx_shift    = 1'b0;
    unique case (r_state)
      IDLE: w_frame_start = w_cs_fall && r_armed;
      CMD: begin
        w_abort    = w_cs_rise;
        w_rx_shift = w_sample && !w_cs_rise;
        w_cmd_done = w_rx_shift && r_bit_cnt == CNT_W'(7);
      end
      DATA: begin
        w_abort     = w_cs_rise;
        w_rx_shift  = w_sample && !w_cs_rise;
        w_data_done = w_rx_shift && r_bit_cnt == CNT_W'(DATA_W - 1);
        w_tx_shift  = w_shift && !w_cs_rise && r_is_rd;
      end
      default: ;
    endcase
  end

  // Datapath: shifters, bit counter, strobes and read-data capture.
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      r_bit_cnt <= '0;
      r_rx      <= '0;
      r_tx      <= '0;
      r_is_rd   <= 1'b0;
      r_cap     <= 1'b0;
      r_miso    <= 1'b0;
      r_we      <= 1'b0;
      r_re      <= 1'b0;
      r_err     <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
    end else begin
      r_we  <= 1'b0;
      r_re  <= 1'b0;
      r_err <= 1'b0;
      // Read data is valid the cycle after the read strobe.
      r_cap <= r_re;
      if (r_cap) r_tx <= reg_rdata_i;
      if (w_frame_start) begin
        r_bit_cnt <= '0;
        r_miso    <= 1'b0;
      end
      if (w_rx_shift) begin
        r_rx      <= w_rx_next;
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end
      if (w_cmd_done) begin
        r_addr    <= w_rx_next[ADDR_W-1:0];
        r_is_rd   <= w_rx_next[CMD_RD_BIT];
        r_re      <= w_rx_next[CMD_RD_BIT];
        r_bit_cnt <= '0;
      end
      if (w_data_done) begin
        if (!r_is_rd) begin
          r_wdata <= w_rx_next;
          r_we    <= 1'b1;
        end
        r_miso <= 1'b0;
      end
      if (w_tx_shift) begin
        r_miso <= r_tx[DATA_W-1];
        r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
      end
      if (w_abort) begin
        r_err  <= 1'b1;
        r_miso <= 1'b0;
      end
    end
  end

  assign spi_miso_o  = r_miso;
  assign reg_addr_o  = r_addr;
  assign reg_wdata_o = r_wdata;
  assign reg_we_o    = r_we;
  assign reg_re_o    = r_re;
  assign frame_err_o = r_err;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Bench for spi_reg_slave: one instance per SPI mode, a host task driving
// frames, and a monitor popping expected strobes from a scoreboard queue.
`timescale 1ns/1ps
module tb_spi_reg_slave;

  localparam int DW = 24;
  localparam int HP = 500;   // SPI half period: 1 MHz

  localparam int K_WE  = 0;
  localparam int K_RE  = 1;
  localparam int K_ERR = 2;

  typedef struct {
    int         mode;
    int         kind;
    logic [6:0] addr;
    logic [DW-1:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  logic mosi;
  logic sclk [4];
  logic cs_n [4];
  logic miso [4];
  logic we   [4];
  logic re   [4];
  logic ferr [4];
  logic [6:0]    addr  [4];
  logic [DW-1:0] wdata [4];
  logic [DW-1:0] rdata [4];
  logic [DW-1:0] rd_val;

  ev_t exp_q [$];
  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dut
      spi_reg_slave #(
        .DATA_BYTES(3), .CPOL(gi >= 2), .CPHA((gi % 2) == 1), .SYNC_STAGES(2)
      ) u_dut (
        .sys_clk_i(clk), .sys_rst_i(rst_n),
        .spi_clk_i(sclk[gi]), .spi_mosi_i(mosi), .spi_cs_i(cs_n[gi]),
        .spi_miso_o(miso[gi]), .reg_addr_o(addr[gi]), .reg_wdata_o(wdata[gi]),
        .reg_we_o(we[gi]), .reg_re_o(re[gi]), .reg_rdata_i(rdata[gi]),
        .frame_err_o(ferr[gi])
      );
      // Register file model: data valid only in the cycle after the read strobe.
      always @(posedge clk) rdata[gi] <= re[gi] ? rd_val : ~rd_val;
    end
  endgenerate

  function automatic void expect_ev(input int m, input int k, input logic [6:0] a,
                                    input logic [DW-1:0] d);
    ev_t e;
    e.mode = m; e.kind = k; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endfunction

  task automatic observe(input int m, input int k, input logic [6:0] a,
                         input logic [DW-1:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL strobe_unexpected: got mode %0d kind %0d addr %h data %h, required none",
               m, k, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.mode != m || e.kind != k || e.addr !== a || e.data !== d) begin
        errors++;
        $display("FAIL strobe: got mode %0d kind %0d addr %h data %h, required mode %0d kind %0d addr %h data %h",
                 m, k, a, d, e.mode, e.kind, e.addr, e.data);
      end else begin
        $display("strobe mode %0d kind %0d addr %h data %h ok", m, k, a, d);
      end
    end
  endtask

  // Monitor: every strobe the DUTs present must match the head of the queue.
  always @(negedge clk) begin
    for (int m = 0; m < 4; m++) begin
      if (we[m] === 1'b1)   observe(m, K_WE, addr[m], wdata[m]);
      if (re[m] === 1'b1)   observe(m, K_RE, addr[m], '0);
      if (ferr[m] === 1'b1) observe(m, K_ERR, '0, '0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end else begin
      $display("check %s = %h ok", name, act);
    end
  endtask

  task automatic reset_pulse(input int m);
    rst_n = 1'b0;
    #1;
    chk("rst_addr", {25'd0, addr[m]}, 32'd0);
    chk("rst_wdata", {8'd0, wdata[m]}, 32'd0);
    chk("rst_flags", {28'd0, we[m], re[m], ferr[m], miso[m]}, 32'd0);
    #99;
    rst_n = 1'b1;
  endtask

  // Host frame: nbits clocks (32 for a full frame), optional reset before bit rst_bit.
  task automatic frame(input int m, input logic [7:0] cmd, input logic [DW-1:0] pl,
                       input int nbits, input int rst_bit, output logic [31:0] rx);
    logic [31:0] w;
    logic cpol, cpha;
    w = {cmd, pl};
    cpol = (m >= 2);
    cpha = ((m % 2) == 1);
    rx = '0;
    cs_n[m] = 1'b0;
    if (!cpha) mosi = w[31];
    #HP;
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_bit) reset_pulse(m);
      if (!cpha) begin
        sclk[m] = ~cpol;
        rx = {rx[30:0], miso[m]};
        #HP;
        sclk[m] = cpol;
        if (i < 31) mosi = w[30-i];
        #HP;
      end else begin
        sclk[m] = ~cpol;
        mosi = w[31-i];
        #HP;
        sclk[m] = cpol;
        rx = {rx[30:0], miso[m]};
        #HP;
      end
    end
    cs_n[m] = 1'b1;
    #HP;
  endtask

  initial begin
    logic [31:0] rx;
    rst_n = 1'b0;
    mosi  = 1'b0;
    rd_val = '0;
    for (int m = 0; m < 4; m++) begin
      sclk[m] = (m >= 2);
      cs_n[m] = 1'b1;
    end
    #50;
    for (int m = 0; m < 4; m++)
      chk("reset_outputs", {3'd0, addr[m], wdata[m]} | {28'd0, we[m], re[m], ferr[m], miso[m]}, 32'd0);
    #50;
    rst_n = 1'b1;
    #1000;

    // Mode 0 write
    expect_ev(0, K_WE, 7'h70, 24'h674523);
    frame(0, 8'h70, 24'h674523, 32, -1, rx);
    chk("wr_miso", rx, 32'h0);
    #5000;

    // Mode 0 read
    rd_val = 24'hA5C3F0;
    expect_ev(0, K_RE, 7'h41, '0);
    frame(0, 8'hC1, 24'h000000, 32, -1, rx);
    chk("rd_miso", rx, 32'h00A5C3F0);
    #5000;

    // Back-to-back frames with 100 us CS-high gaps
    rd_val = 24'h123456;
    expect_ev(0, K_RE, 7'h40, '0);
    frame(0, 8'hC0, 24'h000000, 32, -1, rx);
    chk("b2b_rd0_miso", rx, 32'h00123456);
    #100000;
    expect_ev(0, K_WE, 7'h70, 24'h0F1E2D);
    frame(0, 8'h70, 24'h0F1E2D, 32, -1, rx);
    chk("b2b_wr_miso", rx, 32'h0);
    #100000;
    rd_val = 24'hA5C3F0;
    expect_ev(0, K_RE, 7'h41, '0);
    frame(0, 8'hC1, 24'h000000, 32, -1, rx);
    chk("b2b_rd1_miso", rx, 32'h00A5C3F0);
    #5000;

    // Abort after 12 bits, then a normal frame
    expect_ev(0, K_ERR, '0, '0);
    frame(0, 8'h05, 24'hABCDEF, 12, -1, rx);
    #5000;
    expect_ev(0, K_WE, 7'h05, 24'hABCDEF);
    frame(0, 8'h05, 24'hABCDEF, 32, -1, rx);
    chk("after_abort_miso", rx, 32'h0);
    #5000;

    // Modes 1..3 write, plus reads on the CPHA=1 modes
    for (int m = 1; m < 4; m++) begin
      expect_ev(m, K_WE, 7'h12, 24'hDEADBE);
      frame(m, 8'h12, 24'hDEADBE, 32, -1, rx);
      chk("mode_wr_miso", rx, 32'h0);
      #5000;
    end
    rd_val = 24'h3C5A96;
    expect_ev(1, K_RE, 7'h01, '0);
    frame(1, 8'h81, 24'h000000, 32, -1, rx);
    chk("mode1_rd_miso", rx, 32'h003C5A96);
    #5000;
    expect_ev(3, K_RE, 7'h01, '0);
    frame(3, 8'h81, 24'h000000, 32, -1, rx);
    chk("mode3_rd_miso", rx, 32'h003C5A96);
    #5000;

    // Reset mid-payload: no strobes for that frame, next frame decodes
    frame(0, 8'h33, 24'h778899, 32, 16, rx);
    #5000;
    expect_ev(0, K_WE, 7'h33, 24'h778899);
    frame(0, 8'h33, 24'h778899, 32, -1, rx);
    chk("post_reset_miso", rx, 32'h0);
    #5000;

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_reg_slave.md
# spi_reg_slave

Parametrised SPI slave that decodes framed register transactions for the function generator's host interface. A frame is one command byte followed by `DATA_BYTES` payload bytes. The block turns each frame into single-cycle register write and read strobes in the `sys_clk_i` domain, and returns read data on MISO. It sits between the external interface pins (`int_clk_i`, `int_mosi_i`, `int_miso_o`, `int_cs_i`) and the register file driving the DDS channels. It generalises the fixed-mode, fixed-length host link with a configurable SPI mode, payload width and synchroniser depth, plus framing-error reporting.

## Interface
- `DATA_BYTES`, 3: payload bytes per frame; register data width is `DATA_W = 8*DATA_BYTES`.
- `CPOL`, 0: SPI clock idle level.
- `CPHA`, 0: 0 = sample on leading edge, shift on trailing edge; 1 = the reverse.
- `SYNC_STAGES`, 2: synchroniser flops on `spi_clk_i`, `spi_mosi_i` and `spi_cs_i` (minimum 2).

Ports:
- `sys_clk_i`  in  1  system clock (48 MHz nominal); the only clock.
- `sys_rst_i`  in  1  reset; asynchronous and active-low.
- `spi_clk_i`  in  1  SPI clock from the host; treated as asynchronous data.
- `spi_mosi_i`  in  1  host-to-slave data, MSB first.
- `spi_cs_i`  in  1  chip select, active-low.
- `spi_miso_o`  out  1  slave-to-host data, MSB first.
- `reg_addr_o`  out  7  register address, `cmd[6:0]`; held until the next command byte.
- `reg_wdata_o`  out  DATA_W  write data; valid while `reg_we_o` is high.
- `reg_we_o`  out  1  one-cycle write strobe.
- `reg_re_o`  out  1  one-cycle read strobe.
- `reg_rdata_i`  in  DATA_W  read data; sampled exactly 1 cycle after `reg_re_o`.
- `frame_err_o`  out  1  one-cycle pulse when CS deasserts mid-frame.

## Operation
- Command byte:
  - `cmd[7]` = 1 means read, 0 means write.
  - `cmd[6:0]` is the address.
  - Payload is MSB-byte first.
- Edge detection:
  - Synchronised `spi_clk` is compared with its previous value.
  - Sample edge: rising when `CPOL^CPHA` = 0, else falling.
  - Shift edge: the opposite edge.
- FSM states:
  - IDLE: wait for synchronised CS falling. On entry clear the bit counter and drive MISO 0, then go to CMD.
  - CMD: shift MOSI in on each sample edge. After the 8th, latch `reg_addr_o`. For a read, pulse `reg_re_o`, capture `reg_rdata_i` into the TX shifter on the next cycle, then go to DATA.
  - DATA: shift MOSI in on each sample edge. On the `DATA_W`-th, a write loads `reg_wdata_o` and pulses `reg_we_o`, and a read pulses nothing. Then go to DONE.
  - DONE: ignore further clocks, MISO 0, wait for CS high, then go to IDLE.
- CS rising in CMD or DATA:
  - pulse `frame_err_o`;
  - issue no `reg_we_o`;
  - return to IDLE.
  - A `reg_re_o` already issued is not retracted.
- CS rising in DONE or IDLE: return to IDLE, no error.
- MISO:
  - 0 during CMD, write frames, DONE and IDLE.
  - For reads, bit `DATA_W-1` is driven at the shift edge following the 8th command sample edge, and subsequent bits on each following shift edge.
  - For CPHA=1, the first data bit is driven at the first data-phase shift edge.
- Simultaneous sample edge and CS rise: CS wins; the bit is discarded.

## Timing
- Reset values:
  - all outputs 0;
  - FSM IDLE;
  - synchronisers load idle values (`spi_clk` = CPOL, CS = 1, MOSI = 0).
- Input latency: `SYNC_STAGES` + 1 `sys_clk_i` cycles from a pin edge to the internal edge pulse.
- Strobe timing:
  - `reg_we_o` is asserted 1 cycle after the last payload sample edge is detected.
  - `reg_re_o` is asserted 1 cycle after the 8th command sample edge is detected.
  - `reg_rdata_i` is captured the cycle after `reg_re_o`.
- Supported SPI clock: at most `sys_clk_i`/16. This guarantees that read-data capture precedes the next shift edge.
- Reset mid-frame: returns to IDLE immediately with no strobes. A frame already in progress is ignored until CS goes high and then low again.

## Structure
- Shared package `fg_pkg`:
  - `CMD_RD_BIT` = 7, `ADDR_W` = 7;
  - FSM state enum `spi_st_t` (IDLE, CMD, DATA, DONE).
- Sub-module `sync_edge`:
  - parametrised N-flop synchroniser with rise and fall pulse outputs;
  - instantiated three times.
- The top level holds the FSM, bit counter (`$clog2(DATA_W+8)` bits), RX shifter and TX shifter.

## Test plan
- Write frame 0x70,0x67,0x45,0x23 (mode 0, 1 MHz SPI) -> one `reg_we_o` pulse with `reg_addr_o` = 0x70 and `reg_wdata_o` = 0x674523; `reg_re_o` stays 0; MISO stays 0.
- Read frame 0xC1,0x00,0x00,0x00 with `reg_rdata_i` = 0xA5C3F0 -> `reg_re_o` pulses once with addr 0x41; host receives 0xA5,0xC3,0xF0.
- Back-to-back frames (read 0xC0, write 0x70..., read 0xC1) separated by 100 us CS-high gaps -> exactly two `reg_re_o` and one `reg_we_o` pulse, correct addresses, no `frame_err_o`.
- CS raised after 12 bits of a write -> `frame_err_o` pulses once, no `reg_we_o`; the following full frame decodes normally.
- Modes 1, 2 and 3 (`CPOL`/`CPHA` swept), write 0x12 with 0xDEADBE -> same strobe and data as mode 0.
- `sys_rst_i` low mid-payload -> outputs 0 immediately; no strobe for that frame; the next frame after CS toggles is correct.
